f_ctrl: RTL and testbench

F_CTRL -- requirements
Module: f_ctrl

---
 rtl/f_ctrl.sv | 140 ++++++++++++++
 tb/tb_f_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f_ctrl.sv
// rtl/f_ctrl.sv - BLAKE2 compression round controller (optional F_CTRL_STALL_EN adds g_stall back-pressure)
module f_ctrl #(
    parameter int ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       last_in,
`ifdef F_CTRL_STALL_EN
    input  logic       g_stall,
`endif
    output logic       busy,
    output logic       init_en,
    output logic       g_en,
    output logic [2:0] sub_ctr,
    output logic [3:0] rnd_ctr,
    output logic       fin_en,
    output logic       done,
    output logic       last_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_sub;
    logic [3:0] r_rnd;
    logic       r_last;
    logic       w_stall;
    logic       w_last_step;

`ifdef F_CTRL_STALL_EN
    assign w_stall = g_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Final G step of the final round: the point where ROUND hands over to FINAL
    assign w_last_step = (r_sub == 3'd7) && (r_rnd == LAST_RND);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode; every output depends only on registered state (and g_stall)
    always_comb begin
        w_next  = r_state;
        busy    = 1'b1;
        init_en = 1'b0;
        g_en    = 1'b0;
        fin_en  = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_SETUP;
                end
            end
            S_SETUP: begin
                init_en = 1'b1;
                w_next  = S_ROUND;
            end
            S_ROUND: begin
                g_en = !w_stall;
                if (!w_stall && w_last_step) begin
                    w_next = S_FINAL;
                end
            end
            S_FINAL: begin
                fin_en = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Step counters: run during ROUND, hold the final (7, ROUNDS-1) through FINAL/DONE, zero elsewhere
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sub <= 3'd0;
            r_rnd <= 4'd0;
        end else begin
            case (r_state)
                S_ROUND: begin
                    if (!w_stall && !w_last_step) begin
                        if (r_sub == 3'd7) begin
                            r_sub <= 3'd0;
                            r_rnd <= r_rnd + 4'd1;
                        end else begin
                            r_sub <= r_sub + 3'd1;
                        end
                    end
                end
                S_FINAL: begin
                    r_sub <= r_sub;
                    r_rnd <= r_rnd;
                end
                default: begin
                    r_sub <= 3'd0;
                    r_rnd <= 4'd0;
                end
            endcase
        end
    end

    // Final-block flag captured with the accepted start and held until the next one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_last <= last_in;
        end
    end

    assign sub_ctr = r_sub;
    assign rnd_ctr = r_rnd;
    assign last_q  = r_last;

endmodule

// File: tb/tb_f_ctrl.sv
// tb/tb_f_ctrl.sv - self-checking bench for f_ctrl (ROUNDS=10 and ROUNDS=12 instances)
module tb_f_ctrl;

    logic clk;
    logic rst_n, start, last_in, stall;
    logic busy10, init10, g10, fin10, done10, lastq10;
    logic busy12, init12, g12, fin12, done12, lastq12;
    logic [2:0] sub10, sub12;
    logic [3:0] rnd10, rnd12;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t10    = 0;
    int t12    = 0;
    bit l10    = 0;
    bit l12    = 0;

    f_ctrl #(.ROUNDS(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .last_in(last_in),
`ifdef F_CTRL_STALL_EN
        .g_stall(stall),
`endif
        .busy(busy10), .init_en(init10), .g_en(g10), .sub_ctr(sub10), .rnd_ctr(rnd10),
        .fin_en(fin10), .done(done10), .last_q(lastq10)
    );

    f_ctrl #(.ROUNDS(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .start(start), .last_in(last_in),
`ifdef F_CTRL_STALL_EN
        .g_stall(stall),
`endif
        .busy(busy12), .init_en(init12), .g_en(g12), .sub_ctr(sub12), .rnd_ctr(rnd12),
        .fin_en(fin12), .done(done12), .last_q(lastq12)
    );

    always #5 clk = ~clk;

    // Reference: t = cycles since acceptance (0 = idle), frozen while a ROUND cycle is stalled.
    // t=1 SETUP, t=2..8R+1 G step number t-2, t=8R+2 FINAL, t=8R+3 DONE.
    function automatic int next_t(int t, int r, bit rn, bit st, bit stl);
        if (!rn) return 0;
        if (t == 0) return st ? 1 : 0;
        if (t == 8 * r + 3) return 0;
        if (t >= 2 && t <= 8 * r + 1 && stl) return t;
        return t + 1;
    endfunction

    // Expected {busy, init_en, g_en, fin_en, done, sub_ctr, rnd_ctr, last_q}
    function automatic logic [12:0] exp_vec(int t, int r, bit l, bit stl);
        int  i;
        bit  in_round;
        logic [2:0] s;
        logic [3:0] n;
        in_round = (t >= 2) && (t <= 8 * r + 1);
        if (t < 2) i = 0;
        else if (in_round) i = t - 2;
        else i = 8 * r - 1;
        s = 3'(i % 8);
        n = 4'(i / 8);
        return {t != 0, t == 1, in_round && !stl, t == 8 * r + 2, t == 8 * r + 3, s, n, l};
    endfunction

    function automatic logic [12:0] got10();
        return {busy10, init10, g10, fin10, done10, sub10, rnd10, lastq10};
    endfunction

    function automatic logic [12:0] got12();
        return {busy12, init12, g12, fin12, done12, sub12, rnd12, lastq12};
    endfunction

    // Advance one clock, update the reference from the inputs seen at the edge, settle at negedge
    task automatic step();
        @(posedge clk);
        if (!rst_n) begin
            l10 = 0;
            l12 = 0;
        end else begin
            if (t10 == 0 && start) l10 = last_in;
            if (t12 == 0 && start) l12 = last_in;
        end
        t10 = next_t(t10, 10, rst_n, start, stall);
        t12 = next_t(t12, 12, rst_n, start, stall);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; start = 1; last_in = 1;
        step();
        step();
        checks++;
        if (got10() !== 13'd0) begin
            errors++; $display("FAIL reset10 got=%h exp=%h", got10(), 13'd0);
        end
        checks++;
        if (got12() !== 13'd0) begin
            errors++; $display("FAIL reset12 got=%h exp=%h", got12(), 13'd0);
        end
        rst_n = 1; start = 0; last_in = 0;
        step();
    endtask

    task automatic test_single();
        int n_init = 0, n_g10 = 0, n_g12 = 0, n_fin = 0, lat10 = 0, lat12 = 0, max_rnd12 = 0;
        start = 1; last_in = 1;
        for (int k = 1; k <= 104; k++) begin
            step();
            start = 0; last_in = 0;
            checks++;
            if (got10() !== exp_vec(t10, 10, l10, stall)) begin
                errors++; $display("FAIL single10 cyc=%0d got=%h exp=%h", k, got10(), exp_vec(t10, 10, l10, stall));
            end
            checks++;
            if (got12() !== exp_vec(t12, 12, l12, stall)) begin
                errors++; $display("FAIL single12 cyc=%0d got=%h exp=%h", k, got12(), exp_vec(t12, 12, l12, stall));
            end
            checks++;
            if ($countones({init10, g10, fin10, done10}) > 1 || $countones({init12, g12, fin12, done12}) > 1) begin
                errors++; $display("FAIL onehot_single cyc=%0d got=%b%b exp=at_most_one", k,
                                   {init10, g10, fin10, done10}, {init12, g12, fin12, done12});
            end
            n_init += int'(init10);
            n_fin  += int'(fin10);
            n_g10  += int'(g10);
            n_g12  += int'(g12);
            if (done10) lat10 = k;
            if (done12) lat12 = k;
            if (int'(rnd12) > max_rnd12) max_rnd12 = int'(rnd12);
        end
        checks++;
        if (n_init != 1 || n_fin != 1 || n_g10 != 80) begin
            errors++; $display("FAIL counts10 got=%0d/%0d/%0d exp=1/80/1", n_init, n_g10, n_fin);
        end
        checks++;
        if (lat10 != 83) begin
            errors++; $display("FAIL latency10 got=%0d exp=83", lat10);
        end
        checks++;
        if (n_g12 != 96 || lat12 != 99 || max_rnd12 != 11) begin
            errors++; $display("FAIL run12 got=g%0d/lat%0d/rnd%0d exp=g96/lat99/rnd11", n_g12, lat12, max_rnd12);
        end
    endtask

    task automatic test_back_to_back();
        int last_done = -100, n_init = 0, k0;
        k0 = cyc;
        start = 1; last_in = 0;
        for (int k = 1; k <= 252; k++) begin
            step();
            last_in = k[0];
            checks++;
            if (got10() !== exp_vec(t10, 10, l10, stall)) begin
                errors++; $display("FAIL b2b10 cyc=%0d got=%h exp=%h", k, got10(), exp_vec(t10, 10, l10, stall));
            end
            checks++;
            if (got12() !== exp_vec(t12, 12, l12, stall)) begin
                errors++; $display("FAIL b2b12 cyc=%0d got=%h exp=%h", k, got12(), exp_vec(t12, 12, l12, stall));
            end
            if (init10) begin
                n_init++;
                if (last_done > 0) begin
                    checks++;
                    if (k - last_done != 2) begin
                        errors++; $display("FAIL b2b_gap got=%0d exp=2", k - last_done);
                    end
                end
            end
            if (done10) last_done = k;
        end
        checks++;
        if (n_init != 3) begin
            errors++; $display("FAIL b2b_inits got=%0d exp=3", n_init);
        end
        start = 0;
        for (int k = 0; k < 110 && (t10 != 0 || t12 != 0); k++) step();
        if (cyc < k0) errors++;
    endtask

    task automatic test_reset_mid();
        int n_done = 0, lat = 0;
        start = 1; last_in = 1;
        for (int k = 0; k < 60 && t10 != 2 + 4 * 8 + 3; k++) begin
            step();
            start = 0;
        end
        checks++;
        if (sub10 !== 3'd3 || rnd10 !== 4'd4) begin
            errors++; $display("FAIL mid_pos got=(%0d,%0d) exp=(3,4)", sub10, rnd10);
        end
        rst_n = 0;
        step();
        checks++;
        if (got10() !== exp_vec(t10, 10, l10, stall) || busy10 !== 1'b0 || done10 !== 1'b0) begin
            errors++; $display("FAIL mid_reset got=%h exp=%h", got10(), exp_vec(t10, 10, l10, stall));
        end
        rst_n = 1; start = 1; last_in = 0;
        for (int k = 1; k <= 90; k++) begin
            step();
            start = 0;
            if (k == 1) begin
                checks++;
                if (init10 !== 1'b1) begin
                    errors++; $display("FAIL post_reset_start got=%b exp=1", init10);
                end
            end
            checks++;
            if (got10() !== exp_vec(t10, 10, l10, stall)) begin
                errors++; $display("FAIL mid10 cyc=%0d got=%h exp=%h", k, got10(), exp_vec(t10, 10, l10, stall));
            end
            n_done += int'(done10);
            if (done10) lat = k;
        end
        checks++;
        if (n_done != 1 || lat != 83) begin
            errors++; $display("FAIL mid_recover got=%0d/%0d exp=1/83", n_done, lat);
        end
        for (int k = 0; k < 30 && t12 != 0; k++) step();
    endtask

    task automatic test_random();
        for (int k = 1; k <= 600; k++) begin
            rst_n   = ($urandom % 97) != 0;
            start   = ($urandom % 5) == 0;
            last_in = $urandom % 2;
`ifdef F_CTRL_STALL_EN
            stall   = ($urandom % 4) == 0;
`endif
            step();
            checks++;
            if (got10() !== exp_vec(t10, 10, l10, stall)) begin
                errors++; $display("FAIL rand10 cyc=%0d got=%h exp=%h", k, got10(), exp_vec(t10, 10, l10, stall));
            end
            checks++;
            if (got12() !== exp_vec(t12, 12, l12, stall)) begin
                errors++; $display("FAIL rand12 cyc=%0d got=%h exp=%h", k, got12(), exp_vec(t12, 12, l12, stall));
            end
            checks++;
            if ($countones({init10, g10, fin10, done10}) > 1 || $countones({init12, g12, fin12, done12}) > 1) begin
                errors++; $display("FAIL onehot_rand cyc=%0d got=%b%b exp=at_most_one", k,
                                   {init10, g10, fin10, done10}, {init12, g12, fin12, done12});
            end
        end
        rst_n = 0; start = 0; stall = 0;
        step();
        rst_n = 1;
        step();
    endtask

`ifdef F_CTRL_STALL_EN
    task automatic test_stall();
        int lat = 0;
        start = 1; last_in = 1;
        for (int k = 1; k <= 100; k++) begin
            step();
            start = 0;
            stall = (k >= 81 && k < 86);
            checks++;
            if (got10() !== exp_vec(t10, 10, l10, stall)) begin
                errors++; $display("FAIL stall10 cyc=%0d got=%h exp=%h", k, got10(), exp_vec(t10, 10, l10, stall));
            end
            if (k >= 81 && k < 86) begin
                checks++;
                if (sub10 !== 3'd7 || rnd10 !== 4'd9 || g10 !== 1'b0) begin
                    errors++; $display("FAIL stall_hold cyc=%0d got=(%0d,%0d,g%b) exp=(7,9,g0)", k, sub10, rnd10, g10);
                end
            end
            if (done10) lat = k;
        end
        stall = 0;
        checks++;
        if (lat != 88) begin
            errors++; $display("FAIL stall_latency got=%0d exp=88", lat);
        end
        for (int k = 0; k < 30 && t12 != 0; k++) step();
    endtask
`endif

    initial begin
        clk = 0; rst_n = 0; start = 0; last_in = 0; stall = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
`ifdef F_CTRL_STALL_EN
        test_stall();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
